// File: rtl/noc_pkg.sv
// noc_pkg: packet field layout and destination-legality helper shared by the
// PE-side injection buffer and the routers.
// Packet layout, LSB first: dst_x | dst_y | src_x | src_y | data.
package noc_pkg;
  localparam int DST_X_W   = 2;
  localparam int DST_Y_W   = 2;
  localparam int SRC_X_W   = 8;
  localparam int SRC_Y_W   = 8;
  localparam int DATA_W    = 240;

  localparam int DST_X_LSB = 0;
  localparam int DST_Y_LSB = DST_X_LSB + DST_X_W;
  localparam int SRC_X_LSB = DST_Y_LSB + DST_Y_W;
  localparam int SRC_Y_LSB = SRC_X_LSB + SRC_X_W;
  localparam int DATA_LSB  = SRC_Y_LSB + SRC_Y_W;

  // A destination is legal when it falls inside the mx-by-my mesh.
  function automatic logic dst_legal(input int unsigned dx, input int unsigned dy,
                                     input int unsigned mx, input int unsigned my);
    return (dx < mx) && (dy < my);
  endfunction
endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: synchronous FIFO with show-ahead read.
// Ports: clk, rstn (async low); push/wdata write side; pop/rdata read side
// (rdata is the head entry, 0 when empty); full, empty, count status.
// Pushes while full and pops while empty are ignored.
module noc_sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [width-1:0]           wdata,
  input  logic                       pop,
  output logic [width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth):0]     count
);
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage is not reset; validity is carried entirely by count.
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
endmodule

// File: rtl/noc_inject_buffer.sv
// noc_inject_buffer: injection queue between a PE and its router's local port.
// Ports: clk, rstn (async low); i_data/i_valid/o_ready from the PE;
// o_data/o_valid/i_ready to the router; o_drop pulses one cycle after an
// out-of-mesh packet is swallowed; acceptedCount/sentCount/droppedCount
// statistics; maxOccupancy/stallCycles live only when INJ_STATS_EN is
// defined and read 0 otherwise.
module noc_inject_buffer
  import noc_pkg::*;
#(
  parameter int X           = 4,
  parameter int Y           = 4,
  parameter int data_width  = DATA_W,
  parameter int dest_x      = DST_X_W,
  parameter int dest_y      = DST_Y_W,
  parameter int source_x    = SRC_X_W,
  parameter int source_y    = SRC_Y_W,
  parameter int total_width = dest_x + dest_y + source_x + source_y + data_width,
  parameter int depth       = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [total_width-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [total_width-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_drop,
  output logic [31:0]            acceptedCount,
  output logic [31:0]            sentCount,
  output logic [31:0]            droppedCount,
  output logic [$clog2(depth):0] maxOccupancy,
  output logic [31:0]            stallCycles
);
  localparam int CW = $clog2(depth) + 1;

  logic          full, empty, rdy_q;
  logic [CW-1:0] count;
  logic          accept, legal, push, pop;
  logic [dest_x-1:0] dx;
  logic [dest_y-1:0] dy;

  assign dx     = i_data[DST_X_LSB +: dest_x];
  assign dy     = i_data[DST_X_LSB + dest_x +: dest_y];
  assign legal  = dst_legal(32'(dx), 32'(dy), 32'(X), 32'(Y));

  // rdy_q holds o_ready low through reset and for the release cycle;
  // otherwise ready is purely !full, independent of i_ready.
  assign o_ready = rdy_q & ~full;
  assign o_valid = ~empty;
  assign accept  = i_valid & o_ready;
  assign push    = accept & legal;
  assign pop     = o_valid & i_ready;

  noc_sync_fifo #(.width(total_width), .depth(depth)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (i_data),
    .pop   (pop),
    .rdata (o_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rdy_q         <= 1'b0;
      o_drop        <= 1'b0;
      acceptedCount <= '0;
      sentCount     <= '0;
      droppedCount  <= '0;
    end else begin
      rdy_q  <= 1'b1;
      o_drop <= accept & ~legal;
      if (push)           acceptedCount <= acceptedCount + 32'd1;
      if (pop)            sentCount     <= sentCount + 32'd1;
      if (accept & ~legal) droppedCount <= droppedCount + 32'd1;
    end

`ifdef INJ_STATS_EN
  // High-water mark tracks the registered count, so it lags by one cycle.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      maxOccupancy <= '0;
      stallCycles  <= '0;
    end else begin
      if (count > maxOccupancy) maxOccupancy <= count;
      if (o_valid & ~i_ready)   stallCycles  <= stallCycles + 32'd1;
    end
`else
  assign maxOccupancy = '0;
  assign stallCycles  = '0;
`endif
endmodule
